alu_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU in the pipelined core. It registers decoded operands and the 4-bit `ALU_operation` from decode, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and selects immediate vs. register for `B`. It detects load-use hazards, stalls decode via `id_ready`, inserts bubbles, and supports flush on taken branches.

---
 rtl/alu_operand_stage.sv | 159 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU.
// It latches the decoded operands, forwards results from EX/MEM and MEM/WB,
// and selects the immediate or rs2 for B.
// It also stalls decode on a load-use hazard and inserts bubbles on stall or flush.
//
// Handshake: decode presents an instruction with id_valid. It transfers into EX
// on a rising edge only when id_valid && id_ready && !flush.
// id_ready is a pure function of the current EX contents and the decode addresses.
// It is not registered, and it drops only for a load-use hazard.
// Upstream holds its instruction while id_ready is low. On a flush, upstream
// discards its instruction whatever id_ready shows.
module alu_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src_b,
    input  logic [3:0]      id_alu_op,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            flush,
    input  logic [4:0]      exm_rd_addr,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALU_operation,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_store_data
);

    // EX-stage registers; all-zero is the bubble encoding
    logic            r_valid;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_alu_src_b;
    logic [4:0]      r_rd_addr;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [3:0]      r_alu_op;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;

    logic            w_hazard;
    logic            w_load;
    logic [XLEN-1:0] w_cap_rs1;
    logic [XLEN-1:0] w_cap_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Load-use detection: a load in EX whose destination is read by decode.
    // rs2 is always compared, so an immediate-form instruction may stall needlessly.
    always_comb begin
        w_hazard = 1'b0;
        if (r_valid && r_mem_read && (r_rd_addr != 5'd0) && id_valid &&
            ((r_rd_addr == id_rs1_addr) || (r_rd_addr == id_rs2_addr))) begin
            w_hazard = 1'b1;
        end
    end

    assign id_ready = !w_hazard;
    assign w_load   = id_valid && id_ready && !flush;

    // Capture bypass: a register file without write-through returns stale data
    // for the register being written back this same cycle.
    always_comb begin
        w_cap_rs1 = id_rs1_data;
        w_cap_rs2 = id_rs2_data;
        if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs1_addr)) begin
            w_cap_rs1 = wb_data;
        end
        if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs2_addr)) begin
            w_cap_rs2 = wb_data;
        end
    end

    // EX register update: flush and stall both load a bubble; otherwise accept decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_alu_src_b <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rs1_addr  <= 5'd0;
            r_rs2_addr  <= 5'd0;
            r_alu_op    <= 4'd0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_alu_src_b <= id_alu_src_b;
            r_rd_addr   <= id_rd_addr;
            r_rs1_addr  <= id_rs1_addr;
            r_rs2_addr  <= id_rs2_addr;
            r_alu_op    <= id_alu_op;
            r_rs1_data  <= w_cap_rs1;
            r_rs2_data  <= w_cap_rs2;
            r_imm       <= id_imm;
        end else begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_alu_src_b <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rs1_addr  <= 5'd0;
            r_rs2_addr  <= 5'd0;
            r_alu_op    <= 4'd0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
        end
    end

    // Operand forwarding: EX/MEM wins over MEM/WB, and x0 never forwards.
    // A bubble has rs1 = rs2 = 0 and zero data, so its operands stay 0.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
        if (exm_reg_write && (exm_rd_addr != 5'd0) && (exm_rd_addr == r_rs1_addr)) begin
            w_fwd_rs1 = exm_result;
        end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == r_rs1_addr)) begin
            w_fwd_rs1 = wb_data;
        end
        if (exm_reg_write && (exm_rd_addr != 5'd0) && (exm_rd_addr == r_rs2_addr)) begin
            w_fwd_rs2 = exm_result;
        end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == r_rs2_addr)) begin
            w_fwd_rs2 = wb_data;
        end
    end

    assign A             = w_fwd_rs1;
    assign B             = r_alu_src_b ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ALU_operation = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_rd_addr    = r_rd_addr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage.
// It runs directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the EX slot.
module tb_alu_operand_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic rst_n;

    logic        id_valid, id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src_b;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, flush;
    logic [4:0]  exm_rd_addr;
    logic        exm_reg_write;
    logic [31:0] exm_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [31:0] A, B, ex_store_data;
    logic [3:0]  ALU_operation;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd_addr;

    alu_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src_b(id_alu_src_b), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .A(A), .B(B), .ALU_operation(ALU_operation),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The model holds one instruction in EX, or nothing (a bubble).
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        src_b;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
    } slot_t;

    slot_t m_ex;

    // Latest architectural value of register rs as seen from EX: start with the
    // latched value, then let newer producers overwrite it (WB is older than EX/MEM).
    function automatic logic [31:0] m_value(input logic [4:0] rs, input logic [31:0] latched);
        logic [31:0] v;
        v = latched;
        if (rs != 0 && wb_reg_write && wb_rd_addr == rs)   v = wb_data;
        if (rs != 0 && exm_reg_write && exm_rd_addr == rs) v = exm_result;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs, input logic [31:0] rf);
        if (rs != 0 && wb_reg_write && wb_rd_addr == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic m_stall();
        return m_ex.valid && m_ex.mem_read && m_ex.rd != 0 && id_valid &&
               (m_ex.rd == id_rs1_addr || m_ex.rd == id_rs2_addr);
    endfunction

    task automatic check_model();
        logic [31:0] e_rs2;
        e_rs2 = m_value(m_ex.rs2, m_ex.d2);
        check_val("id_ready", {31'd0, id_ready}, {31'd0, !m_stall()});
        check_val("A", A, m_value(m_ex.rs1, m_ex.d1));
        check_val("B", B, m_ex.src_b ? m_ex.imm : e_rs2);
        check_val("store_data", ex_store_data, e_rs2);
        check_val("alu_op", {28'd0, ALU_operation}, {28'd0, m_ex.op});
        check_val("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex.valid});
        check_val("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_ex.reg_write});
        check_val("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_ex.mem_read});
        check_val("ex_rd", {27'd0, ex_rd_addr}, {27'd0, m_ex.rd});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src_b = 0;
        id_alu_op = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        exm_rd_addr = 0; exm_reg_write = 0; exm_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic src_b, input logic [3:0] op, input logic rw, input logic mr);
        id_valid = 1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src_b = src_b;
        id_alu_op = op; id_reg_write = rw; id_mem_read = mr;
    endtask

    // Called just after a falling edge with inputs applied: check, then cross one rising edge.
    task automatic step();
        slot_t nxt;
        #1;
        check_model();
        nxt = '0;
        if (id_valid && !m_stall() && !flush) begin
            nxt.valid = 1; nxt.reg_write = id_reg_write; nxt.mem_read = id_mem_read;
            nxt.src_b = id_alu_src_b; nxt.rd = id_rd_addr; nxt.rs1 = id_rs1_addr;
            nxt.rs2 = id_rs2_addr; nxt.op = id_alu_op; nxt.imm = id_imm;
            nxt.d1 = m_read(id_rs1_addr, id_rs1_data);
            nxt.d2 = m_read(id_rs2_addr, id_rs2_data);
        end
        @(posedge clk);
        m_ex = nxt;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_A"}, A, 32'd0);
        check_val({tag, "_B"}, B, 32'd0);
        check_val({tag, "_op"}, {28'd0, ALU_operation}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        check_val({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
        check_val({tag, "_mr"}, {31'd0, ex_mem_read}, 32'd0);
        check_val({tag, "_rd"}, {27'd0, ex_rd_addr}, 32'd0);
        check_val({tag, "_store"}, ex_store_data, 32'd0);
        check_val({tag, "_ready"}, {31'd0, id_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_ex = '0;
        drive_idle();
        rst_n = 0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // pass-through
        drive_id(5'd1, 5'd2, 5'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 1'b0, 4'b1001, 1'b1, 1'b0);
        step();
        drive_idle();
        #1;
        check_val("pass_A", A, 32'hA5A5A5A5);
        check_val("pass_B", B, 32'h5A5A5A5A);
        check_val("pass_op", {28'd0, ALU_operation}, 32'd9);
        check_val("pass_valid", {31'd0, ex_valid}, 32'd1);
        step();

        // forwarding priority on rs1 = x5
        drive_id(5'd5, 5'd0, 5'd4, 32'h11111111, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        step();
        drive_idle();
        exm_rd_addr = 5; exm_reg_write = 1; exm_result = 32'h7FFFFFFF;
        wb_rd_addr = 5; wb_reg_write = 1; wb_data = 32'h00000001;
        #1;
        check_val("fwd_exm", A, 32'h7FFFFFFF);
        exm_reg_write = 0;
        #1;
        check_val("fwd_wb", A, 32'h00000001);
        exm_reg_write = 1; exm_rd_addr = 0; wb_rd_addr = 0;
        #1;
        check_val("fwd_x0", A, 32'h11111111);
        step();

        // load-use: lw x6, then add x7, x6, x0
        drive_idle();
        drive_id(5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'h4, 1'b1, 4'd0, 1'b1, 1'b1);
        step();
        drive_idle();
        drive_id(5'd6, 5'd0, 5'd7, 32'h0BAD0BAD, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        check_val("lu_stall", {31'd0, id_ready}, 32'd0);
        step();
        exm_rd_addr = 6; exm_reg_write = 1; exm_result = 32'hCAFEBABE;
        #1;
        check_val("lu_ready", {31'd0, id_ready}, 32'd1);
        check_val("lu_bub_A", A, 32'd0);
        check_val("lu_bub_B", B, 32'd0);
        check_val("lu_bub_op", {28'd0, ALU_operation}, 32'd0);
        step();
        drive_idle();
        exm_rd_addr = 6; exm_reg_write = 1; exm_result = 32'hCAFEBABE;
        #1;
        check_val("lu_fwd_A", A, 32'hCAFEBABE);
        check_val("lu_valid", {31'd0, ex_valid}, 32'd1);
        step();

        // flush
        drive_idle();
        drive_id(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'b0001, 1'b1, 1'b0);
        flush = 1;
        step();
        drive_idle();
        #1;
        check_val("flush_valid", {31'd0, ex_valid}, 32'd0);
        check_val("flush_op", {28'd0, ALU_operation}, 32'd0);
        // flush while stalled
        drive_id(5'd1, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 1'b1, 4'd0, 1'b1, 1'b1);
        step();
        drive_idle();
        drive_id(5'd6, 5'd6, 5'd8, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0010, 1'b1, 1'b0);
        flush = 1;
        #1;
        check_val("fl_stall_ready", {31'd0, id_ready}, 32'd0);
        step();
        drive_idle();
        #1;
        check_val("fl_stall_valid", {31'd0, ex_valid}, 32'd0);
        step();

        // immediate B and writeback capture bypass
        drive_id(5'd9, 5'd10, 5'd11, 32'h12345678, 32'hDEADBEEF, 32'h00000001, 1'b1, 4'd0, 1'b1, 1'b0);
        wb_rd_addr = 9; wb_reg_write = 1; wb_data = 32'h80000000;
        step();
        drive_idle();
        #1;
        check_val("imm_A", A, 32'h80000000);
        check_val("imm_B", B, 32'h00000001);
        check_val("imm_store", ex_store_data, 32'hDEADBEEF);
        step();

        // reset in the middle of a load-use stall
        drive_id(5'd1, 5'd0, 5'd6, 32'h0, 32'h0, 32'h8, 1'b1, 4'd0, 1'b1, 1'b1);
        step();
        drive_idle();
        drive_id(5'd6, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        check_val("rst_pre_stall", {31'd0, id_ready}, 32'd0);
        rst_n = 0;
        #1;
        check_all_zero("midrst");
        m_ex = '0;
        @(negedge clk);
        rst_n = 1;
        drive_idle();

        // randomized traffic; small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rs1_addr  = 5'($urandom_range(0, 7));
            id_rs2_addr  = 5'($urandom_range(0, 7));
            id_rd_addr   = 5'($urandom_range(0, 7));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_alu_src_b = 1'($urandom_range(0, 1));
            id_alu_op    = 4'($urandom_range(0, 15));
            id_reg_write = 1'($urandom_range(0, 1));
            id_mem_read  = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            exm_rd_addr  = 5'($urandom_range(0, 7));
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_result   = $urandom;
            wb_rd_addr   = 5'($urandom_range(0, 7));
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_data      = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
